// File: rtl/divide_request_queue_if.sv
// Bundles the request, result and divider-side signals of divide_request_queue.
// The master side is the environment (producers, consumer, divider); the slave side is the queue.
interface divide_request_queue_if #(
    parameter int DIVIDEND_BITS = 10,
    parameter int DIVISOR_BITS  = 7,
    parameter int TAG_BITS      = 4,
    parameter int DEPTH         = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     req_valid;
    logic                     req_ready;
    logic [DIVIDEND_BITS-1:0] req_dividend;
    logic [DIVISOR_BITS-1:0]  req_divisor;
    logic [TAG_BITS-1:0]      req_tag;

    logic                     res_valid;
    logic                     res_ready;
    logic [DIVIDEND_BITS-1:0] res_quotient;
    logic [DIVISOR_BITS-1:0]  res_remainder;
    logic                     res_error;
    logic [TAG_BITS-1:0]      res_tag;

    logic                     div_valid;
    logic [DIVIDEND_BITS-1:0] div_dividend;
    logic [DIVISOR_BITS-1:0]  div_divisor;
    logic                     div_out_valid;
    logic [DIVIDEND_BITS-1:0] div_quotient;
    logic [DIVISOR_BITS-1:0]  div_remainder;
    logic                     div_error;

    logic [CNT_W-1:0]         occupancy;
    logic                     busy;

    modport master (
        output req_valid, req_dividend, req_divisor, req_tag,
        input  req_ready,
        input  res_valid, res_quotient, res_remainder, res_error, res_tag,
        output res_ready,
        input  div_valid, div_dividend, div_divisor,
        output div_out_valid, div_quotient, div_remainder, div_error,
        input  occupancy, busy
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor, req_tag,
        output req_ready,
        output res_valid, res_quotient, res_remainder, res_error, res_tag,
        input  res_ready,
        output div_valid, div_dividend, div_divisor,
        input  div_out_valid, div_quotient, div_remainder, div_error,
        output occupancy, busy
    );
endinterface

// File: rtl/divide_request_queue.sv
// Issue stage in front of a non-backpressured serial divider: a tagged request FIFO,
// a one-op-in-flight issue FSM and a single valid/ready result slot.
//
// state | meaning
// IDLE  | divider free; issue FIFO head when result slot is empty or draining
// BUSY  | one op in the divider; waiting for its out_valid pulse
module divide_request_queue #(
    parameter int DIVIDEND_BITS = 10,
    parameter int DIVISOR_BITS  = 7,
    parameter int TAG_BITS      = 4,
    parameter int DEPTH         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    divide_request_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("divide_request_queue: DEPTH must be a power of two >= 2");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [DIVIDEND_BITS-1:0] fifo_dividend [DEPTH];
    logic [DIVISOR_BITS-1:0]  fifo_divisor  [DEPTH];
    logic [TAG_BITS-1:0]      fifo_tag      [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic push;
    logic issue;
    logic capture;
    logic drain;

    logic [TAG_BITS-1:0]      fly_tag;
    logic                     res_valid_q;
    logic [DIVIDEND_BITS-1:0] res_quotient_q;
    logic [DIVISOR_BITS-1:0]  res_remainder_q;
    logic                     res_error_q;
    logic [TAG_BITS-1:0]      res_tag_q;

    // A full FIFO refuses even when the head is leaving this cycle.
    assign bus.req_ready = (count != FULL_CNT);
    assign push          = bus.req_valid && bus.req_ready;
    assign drain         = res_valid_q && bus.res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Issuing only into an empty or draining slot guarantees every capture finds it free.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0 && (!res_valid_q || bus.res_ready)) begin
                    issue   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.div_out_valid) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dividend[wr_ptr] <= bus.req_dividend;
            fifo_divisor[wr_ptr]  <= bus.req_divisor;
            fifo_tag[wr_ptr]      <= bus.req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (issue) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, issue})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fly_tag <= '0;
        end else if (issue) begin
            fly_tag <= fifo_tag[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid_q     <= 1'b0;
            res_quotient_q  <= '0;
            res_remainder_q <= '0;
            res_error_q     <= 1'b0;
            res_tag_q       <= '0;
        end else if (capture) begin
            res_valid_q     <= 1'b1;
            res_quotient_q  <= bus.div_quotient;
            res_remainder_q <= bus.div_remainder;
            res_error_q     <= bus.div_error;
            res_tag_q       <= fly_tag;
        end else if (drain) begin
            res_valid_q     <= 1'b0;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(capture && res_valid_q));

    assign bus.div_valid     = issue;
    assign bus.div_dividend  = fifo_dividend[rd_ptr];
    assign bus.div_divisor   = fifo_divisor[rd_ptr];
    assign bus.res_valid     = res_valid_q;
    assign bus.res_quotient  = res_quotient_q;
    assign bus.res_remainder = res_remainder_q;
    assign bus.res_error     = res_error_q;
    assign bus.res_tag       = res_tag_q;
    assign bus.occupancy     = count;
    assign bus.busy          = (state_q == BUSY);
endmodule

// File: doc/divide_request_queue.md
Name: divide_request_queue

Overview:
- Upstream issue stage for slow_divider_unsigned.
- Buffers tagged divide requests in a small FIFO and issues them to the divider one at a time, only when the divider is idle.
- Captures each divider result pulse, pairs it with the request's tag, and holds it on a valid/ready result port.
- Lets producers and consumers that stall freely use the divider, which itself has no backpressure.

Parameters:
- DIVIDEND_BITS, 10, width of dividend and quotient
- DIVISOR_BITS, 7, width of divisor and remainder
- TAG_BITS, 4, width of the opaque request tag
- DEPTH, 4, request FIFO entries; must be a power of two, ≥2

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request offered
- req_ready  out  1  FIFO can accept a request
- req_dividend  in  DIVIDEND_BITS  dividend
- req_divisor  in  DIVISOR_BITS  divisor
- req_tag  in  TAG_BITS  tag returned with the result
- res_valid  out  1  result held
- res_ready  in  1  consumer takes the result
- res_quotient  out  DIVIDEND_BITS  quotient
- res_remainder  out  DIVISOR_BITS  remainder
- res_error  out  1  divide-by-zero
- res_tag  out  TAG_BITS  tag of the result
- div_valid  out  1  issue strobe to divider in_valid
- div_dividend  out  DIVIDEND_BITS  to divider in_dividend
- div_divisor  out  DIVISOR_BITS  to divider in_divisor
- div_out_valid  in  1  divider out_valid pulse
- div_quotient  in  DIVIDEND_BITS  divider out_quotient
- div_remainder  in  DIVISOR_BITS  divider out_remainder
- div_error  in  1  divider out_error
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count
- busy  out  1  op in flight in divider

Behaviour:
- Reset values:
  - FIFO empty; occupancy=0; req_ready=1.
  - res_valid=0; res_quotient, res_remainder, res_error, res_tag all 0.
  - busy=0; div_valid=0; state=IDLE.
  - The divider instance shares rst and is idle the cycle after rst deasserts.
- Request side:
  - Push when req_valid && req_ready.
  - req_ready = occupancy != DEPTH; no pop-through when full, even if an issue happens the same cycle.
  - Pointers wrap modulo DEPTH.
- No bypass: a request pushed in cycle N is issuable at the earliest in cycle N+1.
- State machine IDLE/BUSY:
  - IDLE: div_valid = occupancy != 0 && (!res_valid || res_ready). Combinational output.
  - div_dividend and div_divisor are driven from the FIFO head at all times.
  - The head tag is latched into an in-flight tag register.
  - When div_valid=1: pop FIFO, go to BUSY, busy=1.
  - BUSY: div_valid=0. On div_out_valid:
    - load the result register with div_quotient, div_remainder, div_error and the in-flight tag;
    - set res_valid=1;
    - go to IDLE.
  - The earliest next issue is the following cycle. No issue occurs in the capture cycle.
- Result-slot guarantee: an issue requires the result slot to be empty or draining that cycle. A completing result therefore always finds the slot free; nothing overwrites a held result.
- Result port:
  - res_valid and the result fields stay stable until res_valid && res_ready.
  - After a handshake, res_valid drops next cycle unless a capture occurs the same cycle. Capture and drain cannot coincide under the issue rule.
- Ordering: results return strictly in request order; at most one op is in flight.
- res_error is passed through unmodified. When res_error=1, quotient/remainder values are don't-care and must not be checked.
- div_out_valid while IDLE is ignored: no state change, no result.
- Simultaneous push and pop: occupancy unchanged; data integrity preserved at every occupancy including wrap.
- rst asserted mid-operation:
  - FIFO, result slot and in-flight op are discarded.
  - Outputs return to reset values the next cycle, regardless of req_valid, res_ready or div_out_valid that cycle.

Test Plan:
- Single op: push {799,23,tag 3} into empty queue with res_ready=1 -> div_valid pulses 1 cycle after push; result quotient=34, remainder=17, error=0, tag=3; busy returns to 0 on the capture cycle.
- Divide by zero: push {100,0,tag 5} -> res_error=1, tag=5; quotient/remainder not checked; next queued op {256,2} returns 128 r0.
- Fill and order: hold res_ready=0 and push 5 requests with tags 0-4 -> req_ready low after 4 accepted in FIFO plus 1 in flight. Exactly one div_valid until tag 0 is drained. Results emerge in tag order 0..4: {470,12}=39r2, {2,64}=0r2, {0,50}=0r0, {799,17}=47r0, {256,2}=128r0.
- Backpressure hold: result captured with res_ready=0 for 20 cycles -> res_valid and the result fields stay constant, and div_valid stays 0 while the FIFO is non-empty.
- Wrap-around: stream 12 requests with random res_ready -> occupancy never exceeds 4, all results match a reference model, order preserved.
- Reset mid-op: assert rst 3 cycles after issue of {799,23} -> next cycle busy=0, res_valid=0, occupancy=0. A following request {470,12} returns 39 r2 with no stale result.
